pf_read_sequencer: RTL and testbench
====================================

# pf_read_sequencer

Readout sequencer for the pre-FIFO read datapath. It drains one event of NWORDS 16-bit words from the pre-FIFO read FSM by generating its PF_RD advance strobe and paced by a downstream ready.

- In raw-ECC mode each 48-bit FIFO entry yields three words. The sequencer tracks the word phase and pads after the last word so the read FSM is always left on a word-0 boundary.
- It also times out when the FIFO stays empty.

It sits between the event builder (START/NWORDS/DRDY) and the read FSM (PF_RD, with ECC/DECODE shared).

## Interface
- CNT_W, 12, width of NWORDS and the remaining-word counter
- TMO_CYC, 1023, number of empty-wait cycles before abort (≥1)

Ports:
- CLK  in  1  single clock; all state updates on posedge CLK
- RST  in  1  asynchronous reset, active-high
- START  in  1  event readout request (pulse); accepted only when BUSY=0
- NWORDS  in  CNT_W  16-bit words to read; sampled with accepted START
- ECC  in  1  ECC mode; sampled with START, static while BUSY
- DECODE  in  1  decode mode; sampled with START, static while BUSY
- EMPTY  in  1  pre-FIFO empty
- DRDY  in  1  downstream can take a word this cycle
- PF_RD  out  1  advance strobe to the read FSM (combinational)
- DAV  out  1  the word on the read FSM's OUT_DATA is valid and consumed this cycle (combinational)
- BUSY  out  1  registered; high in RUN and PAD
- DONE  out  1  registered; one-cycle pulse at event end
- ERR  out  1  registered, sticky timeout flag
- REM  out  CNT_W  remaining words, registered

## Operation
- raw = ECC & !DECODE, latched at START into raw_r.
- phase register, 2 bits:
  - Values 0,1,2; mirrors the read FSM's Wrd_0/1/2.
  - Cleared by reset and by an accepted START.
  - Outside raw mode it stays 0.
- avail = (phase!=0) | !EMPTY. Phases 1 and 2 reuse an entry that is already popped-ready, so they never wait on EMPTY.
- States: IDLE, RUN, PAD, FIN.
- IDLE:
  - START → load REM=NWORDS, raw_r, phase=0, tmo=0, ERR=0.
  - If NWORDS=0 go to FIN, else go to RUN.
- RUN:
  - DAV = PF_RD = DRDY & avail.
  - On DAV: REM−1, tmo=0, and phase advances (0→1→2→0) if raw_r.
  - On DAV with REM=1:
    - raw_r and next phase≠0 → PAD.
    - Otherwise → FIN.
  - Empty wait: DRDY & EMPTY & phase=0 increments tmo. When tmo reaches TMO_CYC−1 and the wait persists: set ERR and go to FIN. No PF_RD is issued in that cycle.
  - A cycle with DRDY=0 neither advances nor counts.
- PAD:
  - PF_RD=1, DAV=0, independent of DRDY and EMPTY.
  - phase advances each cycle; leave to FIN when phase wraps to 0. This takes 1 or 2 cycles.
- FIN: DONE=1 for one cycle, BUSY=0, → IDLE.
- START while BUSY or in FIN is ignored.
- ECC/DECODE changes while BUSY are illegal; no recovery is required.
- Reset (any time, including mid-RUN/PAD):
  - State → IDLE; phase=0, REM=0, tmo=0.
  - Outputs BUSY=0, DONE=0, ERR=0, PF_RD=0, DAV=0.
  - The read FSM shares RST, so alignment is restored.

## Timing
- START at cycle 0 → BUSY=1 at cycle 1; the first possible PF_RD/DAV is at cycle 1.
- PF_RD/DAV follow DRDY/EMPTY combinationally in the same cycle. There is no registered delay and throughput is one word per cycle.
- Last DAV at cycle k:
  - With no padding: DONE=1 and BUSY=0 at cycle k+1.
  - With padding p (1–2 cycles): PAD occupies k+1..k+p, DONE at k+p+1.
- NWORDS=0: DONE at cycle 1, BUSY never rises, PF_RD never asserted.
- Timeout: with TMO_CYC=N and continuous empty-wait from cycle 1, ERR=1 and DONE=1 at cycle N+1. ERR holds until the next accepted START.
- REM updates on the clock edge after each DAV.

## Test plan
- Non-raw (ECC=1, DECODE=1), NWORDS=4, EMPTY=0, DRDY=1, START@0:
  - PF_RD=DAV=1 cycles 1–4.
  - REM 4→0.
  - DONE@5, ERR=0.
- Raw (ECC=1, DECODE=0), NWORDS=4:
  - DAV cycles 1–4.
  - PF_RD cycles 1–6; cycles 5–6 are PAD with DAV=0.
  - DONE@7, phase=0 at end.
  - Repeat with NWORDS=3: no PAD, DONE@4.
- Raw, NWORDS=6, EMPTY=1 during cycles 2–3 and at cycle 4:
  - Cycles 2–3 are phases 1–2, so there is no stall.
  - The stall happens at cycle 4 (phase 0) until EMPTY drops.
  - DRDY=0 on alternate cycles halves the DAV rate with no word lost.
- TMO_CYC=8, NWORDS=2, EMPTY=1 always:
  - No PF_RD.
  - ERR=1 and DONE=1 at cycle 9.
  - The next START clears ERR.
- NWORDS=0 → DONE@1, no PF_RD. A second START while BUSY is ignored, and REM is unchanged.
- RST asserted mid-RUN at REM=3:
  - Immediately BUSY=0, PF_RD=0, REM=0.
  - After release, a new START with NWORDS=2 completes normally, DONE@3.

Source files
------------

// File: rtl/pf_read_sequencer_if.sv
// pf_read_sequencer_if: handshake bundle between event builder, readout sequencer and read FSM
interface pf_read_sequencer_if #(parameter int CNT_W = 12);
  logic START, ECC, DECODE, EMPTY, DRDY, PF_RD, DAV, BUSY, DONE, ERR;
  logic [CNT_W-1:0] NWORDS, REM;
  modport master(output START, NWORDS, ECC, DECODE, EMPTY, DRDY, input PF_RD, DAV, BUSY, DONE, ERR, REM);
  modport slave(input START, NWORDS, ECC, DECODE, EMPTY, DRDY, output PF_RD, DAV, BUSY, DONE, ERR, REM);
endinterface

// File: rtl/pf_read_sequencer.sv
// pf_read_sequencer: drains one event from the pre-FIFO read FSM, keeping raw-ECC word phase aligned
module pf_read_sequencer #(
  parameter int CNT_W = 12,
  parameter int TMO_CYC = 1023
) (
  input logic CLK,
  input logic RST,
  pf_read_sequencer_if.slave bus
);
  localparam int TW = $clog2(TMO_CYC + 1);
  typedef enum logic [1:0] {IDLE, RUN, PAD, FIN} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] rem;
  logic [TW-1:0] tmo;
  logic [1:0] phase, phase_inc;
  logic raw_r, err, avail, dav, wait_e, tmo_hit, accept;
  assign accept = state == IDLE && bus.START;
  assign phase_inc = phase == 2'd2 ? 2'd0 : phase + 2'd1;
  // phases 1 and 2 consume an entry already popped, so only phase 0 depends on EMPTY
  assign avail = phase != 2'd0 || !bus.EMPTY;
  assign dav = state == RUN && bus.DRDY && avail;
  assign wait_e = state == RUN && bus.DRDY && bus.EMPTY && phase == 2'd0;
  assign tmo_hit = wait_e && tmo == TW'(TMO_CYC - 1);
  assign bus.DAV = dav;
  assign bus.PF_RD = dav || state == PAD;
  assign bus.BUSY = state == RUN || state == PAD;
  assign bus.DONE = state == FIN;
  assign bus.ERR = err;
  assign bus.REM = rem;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.START ? (bus.NWORDS == '0 ? FIN : RUN) : IDLE;
      RUN: state_nx = (dav && rem == CNT_W'(1)) ? ((raw_r && phase_inc != 2'd0) ? PAD : FIN) : (tmo_hit ? FIN : RUN);
      PAD: state_nx = phase_inc == 2'd0 ? FIN : PAD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      rem <= '0;
      tmo <= '0;
      phase <= 2'd0;
      raw_r <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rem <= bus.NWORDS;
        raw_r <= bus.ECC && !bus.DECODE;
        phase <= 2'd0;
        tmo <= '0;
        err <= 1'b0;
      end else if (dav) begin
        rem <= rem - CNT_W'(1);
        tmo <= '0;
        phase <= raw_r ? phase_inc : phase;
      end else if (state == PAD) begin
        phase <= phase_inc;
      end else if (tmo_hit) begin
        err <= 1'b1;
      end else if (wait_e) begin
        tmo <= tmo + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_pf_read_sequencer.sv
// tb_pf_read_sequencer: directed event readouts checked against an event-level model every cycle
module tb_pf_read_sequencer;
  localparam int TMO = 8;
  logic CLK, RST;
  int tests = 0, fails = 0;
  pf_read_sequencer_if #(.CNT_W(12)) bus();
  pf_read_sequencer #(.CNT_W(12), .TMO_CYC(TMO)) dut(.CLK(CLK), .RST(RST), .bus(bus));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  // model: an event is N words followed by (3 - N%3)%3 pad strobes in raw mode
  bit m_active, m_done, m_err, m_raw;
  int m_words, m_pad, m_cnt, m_wait, m_rem;
  initial forever begin
    int ph;
    bit e_dav, e_pf, was_done;
    @(negedge CLK);
    if (RST) begin
      m_active = 0; m_done = 0; m_err = 0; m_raw = 0;
      m_words = 0; m_pad = 0; m_cnt = 0; m_wait = 0; m_rem = 0;
    end
    ph = m_raw ? m_cnt % 3 : 0;
    e_dav = m_active && m_words > 0 && bus.DRDY && (ph != 0 || !bus.EMPTY);
    e_pf = e_dav || (m_active && m_words == 0 && m_pad > 0);
    chk("PF_RD", int'(bus.PF_RD), int'(e_pf));
    chk("DAV", int'(bus.DAV), int'(e_dav));
    chk("BUSY", int'(bus.BUSY), int'(m_active));
    chk("DONE", int'(bus.DONE), int'(m_done));
    chk("ERR", int'(bus.ERR), int'(m_err));
    chk("REM", int'(bus.REM), m_rem);
    if (!RST) begin
      was_done = m_done;
      m_done = 0;
      if (!m_active && !was_done) begin
        if (bus.START) begin
          m_raw = bus.ECC && !bus.DECODE;
          m_rem = int'(bus.NWORDS);
          m_words = m_rem;
          m_pad = m_raw ? (3 - m_rem % 3) % 3 : 0;
          m_cnt = 0; m_wait = 0; m_err = 0;
          m_active = m_rem != 0;
          m_done = m_rem == 0;
        end
      end else if (m_active && m_words > 0) begin
        if (e_dav) begin
          m_words--; m_rem--; m_cnt++; m_wait = 0;
          if (m_words == 0 && m_pad == 0) begin m_active = 0; m_done = 1; end
        end else if (bus.DRDY && bus.EMPTY && ph == 0) begin
          if (m_wait == TMO - 1) begin m_err = 1; m_active = 0; m_done = 1; end
          else m_wait++;
        end
      end else if (m_active) begin
        m_pad--;
        if (m_pad == 0) begin m_active = 0; m_done = 1; end
      end
    end
  end
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic run(input string nm, input int n, input bit ecc, input bit dec,
                     input logic [63:0] em, input logic [63:0] dm, input logic [63:0] sm,
                     input int x_dav, input int x_pf, input int x_busy, input int x_done, input int x_err);
    int davs = 0, pfs = 0, busy = 0, done_c = -1, errv = 0;
    for (int c = 0; c < 64 && done_c < 0; c++) begin
      bus.START = sm[c];
      bus.NWORDS = c == 0 ? 12'(n) : 12'd9;
      bus.ECC = ecc;
      bus.DECODE = dec;
      bus.EMPTY = em[c];
      bus.DRDY = dm[c];
      @(negedge CLK);
      if (c > 0) begin
        davs += int'(bus.DAV);
        pfs += int'(bus.PF_RD);
        busy += int'(bus.BUSY);
        if (bus.DONE) begin done_c = c; errv = int'(bus.ERR); end
      end
      tick();
    end
    bus.START = 0; bus.EMPTY = 0; bus.DRDY = 1;
    chk({nm, " dav count"}, davs, x_dav);
    chk({nm, " pf_rd count"}, pfs, x_pf);
    chk({nm, " busy cycles"}, busy, x_busy);
    chk({nm, " done cycle"}, done_c, x_done);
    chk({nm, " err at done"}, errv, x_err);
    tick();
  endtask
  localparam logic [63:0] ONES = '1;
  initial begin
    RST = 1;
    bus.START = 0; bus.NWORDS = '0; bus.ECC = 0; bus.DECODE = 0; bus.EMPTY = 0; bus.DRDY = 1;
    tick(); tick();
    chk("reset BUSY", int'(bus.BUSY), 0);
    chk("reset DONE", int'(bus.DONE), 0);
    chk("reset PF_RD", int'(bus.PF_RD), 0);
    chk("reset REM", int'(bus.REM), 0);
    RST = 0;
    tick();
    run("nonraw4", 4, 1, 1, 64'h0, ONES, 64'h1, 4, 4, 4, 5, 0);
    chk("nonraw4 REM end", int'(bus.REM), 0);
    run("raw4_restart_ignored", 4, 1, 0, 64'h0, ONES, 64'h5, 4, 6, 6, 7, 0);
    run("raw3_start_in_fin", 3, 1, 0, 64'h0, ONES, 64'h11, 3, 3, 3, 4, 0);
    run("raw5_pad1", 5, 1, 0, 64'h0, ONES, 64'h1, 5, 6, 6, 7, 0);
    run("raw6_empty_stall", 6, 1, 0, 64'h1C, ONES, 64'h1, 6, 6, 7, 8, 0);
    run("raw6_drdy_alt", 6, 1, 0, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h1, 6, 6, 11, 12, 0);
    run("timeout", 2, 1, 1, ONES, ONES, 64'h1, 0, 0, 8, 9, 1);
    chk("err sticky idle", int'(bus.ERR), 1);
    run("after_timeout", 1, 0, 0, 64'h0, ONES, 64'h1, 1, 1, 1, 2, 0);
    run("nwords0", 0, 1, 0, 64'h0, ONES, 64'h1, 0, 0, 0, 1, 0);
    bus.START = 1; bus.NWORDS = 12'd5; bus.ECC = 0; bus.DECODE = 0;
    tick();
    bus.START = 0;
    tick(); tick();
    chk("pre-reset REM", int'(bus.REM), 3);
    RST = 1;
    #1;
    chk("midrun rst BUSY", int'(bus.BUSY), 0);
    chk("midrun rst PF_RD", int'(bus.PF_RD), 0);
    chk("midrun rst REM", int'(bus.REM), 0);
    tick();
    RST = 0;
    tick();
    run("after_reset", 2, 0, 0, 64'h0, ONES, 64'h1, 2, 2, 2, 3, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
